sram_port_ctrl: RTL and testbench

- Responder side of the sram_trig / sram_rw / sram_done handshake issued by the image control unit.
- Drives the external 16-bit asynchronous SRAM that holds the left, right and disparity images.
- Maps an 8-bit pixel access (bank select plus pixel address) onto one byte lane of the SRAM.
- Completes one read or write per handshake and holds read data for the UART TX and window-load paths.

---
 rtl/sram_port_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_sram_port_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_ctrl.sv
// sram_port_ctrl: responder for the sram_trig / sram_rw / sram_done handshake.
// Maps one 8-bit pixel access (bank + pixel address) onto one byte lane of a
// 16-bit asynchronous SRAM and runs a fixed SETUP / ACCESS / HOLD strobe
// sequence. Every SRAM pin and sram_done comes straight from a flop.
//
// done stays low for WAIT_CYCLES+3 cycles per access: after HOLD, the first
// IDLE cycle is a bus turnaround cycle in which done is still low. It only
// rises once trig is seen low, so a request left high (WAIT_REL) and a request
// dropped early release done through the same rule.
module sram_port_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               sram_trig,
    input  logic               sram_rw,
    input  logic [1:0]         mem_bank_sel,
    input  logic [ADDR_W-1:0]  pix_addr,
    input  logic [7:0]         wr_data,
    output logic               sram_done,
    output logic [7:0]         rd_data,
    output logic [SRAM_AW-1:0] sram_addr,
    inout  wire  [15:0]        sram_dq,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_HOLD,
        ST_WAIT_REL
    } state_t;

    // The ACCESS counter runs WAIT_CYCLES-1 down to 0.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t               state_q, state_d;
    logic                 rw_q, rw_d;
    logic                 lane_q, lane_d;
    logic [SRAM_AW-1:0]   addr_q, addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 done_q, done_d;
    logic                 ce_n_q, ce_n_d;
    logic                 oe_n_q, oe_n_d;
    logic                 we_n_q, we_n_d;
    logic                 ub_n_q, ub_n_d;
    logic                 lb_n_q, lb_n_d;
    logic                 dq_oe_q, dq_oe_d;
    logic                 active_d;
    logic [7:0]           rd_lane;

    // Byte lane chosen by the low pixel address bit of the captured request.
    assign rd_lane = lane_q ? sram_dq[15:8] : sram_dq[7:0];

    // Next-state, request capture, read capture, and strobe values for the state being entered.
    always_comb begin
        state_d   = state_q;
        rw_d      = rw_q;
        lane_d    = lane_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        rd_data_d = rd_data_q;
        done_d    = done_q;

        case (state_q)
            ST_IDLE: begin
                if (done_q) begin
                    if (sram_trig) begin
                        state_d = ST_SETUP;
                        done_d  = 1'b0;
                        rw_d    = sram_rw;
                        lane_d  = pix_addr[0];
                        wdata_d = wr_data;
                        addr_d  = '0;
                        addr_d[ADDR_W:0] = {mem_bank_sel, pix_addr[ADDR_W-1:1]};
                    end
                end else begin
                    // Turnaround cycle after HOLD; release only with trig low.
                    done_d = !sram_trig;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = CNT_LOAD;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_HOLD;
                    if (rw_q) begin
                        rd_data_d = rd_lane;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                state_d = sram_trig ? ST_WAIT_REL : ST_IDLE;
            end
            ST_WAIT_REL: begin
                if (!sram_trig) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        endcase

        // Chip and lane stay enabled through HOLD so write data is held against
        // the rising WE_n edge; OE_n/WE_n are confined to SETUP/ACCESS.
        active_d = (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
        ce_n_d   = !active_d;
        ub_n_d   = !(active_d && lane_d);
        lb_n_d   = !(active_d && !lane_d);
        oe_n_d   = !(rw_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS)));
        we_n_d   = !(!rw_d && (state_d == ST_ACCESS));
        dq_oe_d  = !rw_d && active_d;
    end

    // State, captured request and registered SRAM pins; reset forces the bus idle at once.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            rw_q      <= 1'b0;
            lane_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 8'h00;
            cnt_q     <= 4'd0;
            rd_data_q <= 8'h00;
            done_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            oe_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            ub_n_q    <= 1'b1;
            lb_n_q    <= 1'b1;
            dq_oe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rw_q      <= rw_d;
            lane_q    <= lane_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            rd_data_q <= rd_data_d;
            done_q    <= done_d;
            ce_n_q    <= ce_n_d;
            oe_n_q    <= oe_n_d;
            we_n_q    <= we_n_d;
            ub_n_q    <= ub_n_d;
            lb_n_q    <= lb_n_d;
            dq_oe_q   <= dq_oe_d;
        end
    end

    // The write byte is replicated on both lanes; the lane strobes pick the one stored.
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        assign sram_dq[gi*8 +: 8] = dq_oe_q ? wdata_q : 8'hzz;
    end

    assign sram_done = done_q;
    assign rd_data   = rd_data_q;
    assign sram_addr = addr_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: a transaction-level reference (pixel store indexed
// by {bank, pixel address}, cycle offset from request capture) predicts every
// output each cycle; a word-wide SRAM model answers reads and records writes.
module tb_sram_port_ctrl;

    localparam int ADDR_W  = 16;
    localparam int SRAM_AW = 18;
    localparam int WAIT    = 2;

    logic               clk_in       = 1'b0;
    logic               rst_in       = 1'b1;
    logic               sram_trig    = 1'b0;
    logic               sram_rw      = 1'b0;
    logic [1:0]         mem_bank_sel = 2'b00;
    logic [ADDR_W-1:0]  pix_addr     = '0;
    logic [7:0]         wr_data      = 8'h00;
    logic               sram_done;
    logic [7:0]         rd_data;
    logic [SRAM_AW-1:0] sram_addr;
    wire  [15:0]        sram_dq;
    logic               sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_port_ctrl #(
        .ADDR_W     (ADDR_W),
        .SRAM_AW    (SRAM_AW),
        .WAIT_CYCLES(WAIT)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .sram_trig   (sram_trig),
        .sram_rw     (sram_rw),
        .mem_bank_sel(mem_bank_sel),
        .pix_addr    (pix_addr),
        .wr_data     (wr_data),
        .sram_done   (sram_done),
        .rd_data     (rd_data),
        .sram_addr   (sram_addr),
        .sram_dq     (sram_dq),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    always #5 clk_in = ~clk_in;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Storage: external SRAM words and the reference pixel store.
    logic [15:0] mem     [0:(1<<SRAM_AW)-1];
    logic [7:0]  ref_pix [0:(1<<18)-1];

    // Reference model state.
    logic        m_busy  = 1'b0;
    logic        m_done  = 1'b1;
    logic        m_rw    = 1'b0;
    int          m_phase = 0;
    logic [1:0]  m_bank  = 2'b00;
    logic [15:0] m_addr  = 16'h0000;
    logic [7:0]  m_wd    = 8'h00;
    logic [7:0]  m_rd    = 8'h00;
    logic [17:0] m_saddr = 18'h0;

    // SRAM model drives only under CE_n&OE_n; otherwise the bench drives 0 wherever
    // the controller must not drive, so a stray controller driver shows on the bus.
    wire        e_drive       = m_busy && !m_rw;
    wire        sram_rd_drive = !sram_ce_n && !sram_oe_n;
    wire [15:0] sram_word     = mem[sram_addr];
    assign sram_dq = (!e_drive || sram_rd_drive) ? (sram_rd_drive ? sram_word : 16'h0000) : 16'hzzzz;

    // Reference model: phase = cycles since capture (1 setup, 2..WAIT+1 strobe, WAIT+2 hold).
    initial forever begin
        @(posedge clk_in or negedge rst_in);
        if (!rst_in) begin
            m_busy  = 1'b0;
            m_phase = 0;
            m_done  = 1'b1;
            m_rd    = 8'h00;
            m_saddr = 18'h0;
        end else if (m_busy) begin
            if (m_phase == WAIT + 1 && m_rw)
                m_rd = ref_pix[{m_bank, m_addr}];
            if (m_phase == WAIT + 2) begin
                m_busy = 1'b0;
                if (!m_rw) ref_pix[{m_bank, m_addr}] = m_wd;
            end else begin
                m_phase++;
            end
        end else if (m_done) begin
            if (sram_trig) begin
                m_rw    = sram_rw;
                m_bank  = mem_bank_sel;
                m_addr  = pix_addr;
                m_wd    = wr_data;
                m_saddr = 18'((int'(m_bank) * 65536 + int'(m_addr)) / 2);
                m_busy  = 1'b1;
                m_phase = 1;
                m_done  = 1'b0;
            end
        end else begin
            m_done = !sram_trig;
        end
    end

    // Per-cycle compare on the falling edge, then the SRAM model stores any write.
    initial forever begin
        @(negedge clk_in);
        chk("done", sram_done, m_done);
        chk("rd_data", rd_data, m_rd);
        chk("sram_addr", sram_addr, m_saddr);
        chk("ce_n", sram_ce_n, !m_busy);
        chk("ub_n", sram_ub_n, !(m_busy && m_addr[0]));
        chk("lb_n", sram_lb_n, !(m_busy && !m_addr[0]));
        chk("oe_n", sram_oe_n, !(m_busy && m_rw && m_phase <= WAIT + 1));
        chk("we_n", sram_we_n, !(m_busy && !m_rw && m_phase >= 2 && m_phase <= WAIT + 1));
        chk("dq", sram_dq, e_drive ? {m_wd, m_wd} : (sram_rd_drive ? sram_word : 16'h0000));
        chk("oe_we_overlap", !sram_oe_n && !sram_we_n, 1'b0);
        if (!sram_ce_n && !sram_we_n) begin
            if (!sram_lb_n) mem[sram_addr][7:0]  = sram_dq[7:0];
            if (!sram_ub_n) mem[sram_addr][15:8] = sram_dq[15:8];
        end
    end

    // Observations from the most recent access.
    int          t_low, t_we, t_ce;
    logic [17:0] t_addr;
    logic        t_ub, t_lb;
    logic [15:0] t_dq;

    // One handshake: trig drops once done has been seen low for 'hold' falling edges.
    task automatic access(input logic rw, input logic [1:0] bank, input logic [15:0] addr,
                          input logic [7:0] wd, input int hold);
        int  n;
        bit  seen_low;
        @(posedge clk_in);
        #2;
        n = 0;
        while (sram_done !== 1'b1 && n < 40) begin
            @(posedge clk_in);
            #2;
            n++;
        end
        chk("ready_before_trig", sram_done, 1'b1);
        sram_rw      = rw;
        mem_bank_sel = bank;
        pix_addr     = addr;
        wr_data      = wd;
        sram_trig    = 1'b1;
        t_low = 0; t_we = 0; t_ce = 0; seen_low = 1'b0;
        t_addr = '0; t_ub = 1'b1; t_lb = 1'b1; t_dq = '0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (!sram_ce_n) begin
                if (t_ce == 0) begin
                    t_addr = sram_addr;
                    t_ub   = sram_ub_n;
                    t_lb   = sram_lb_n;
                end
                t_ce++;
            end
            if (!sram_we_n) begin
                t_we++;
                t_dq = sram_dq;
            end
            if (!sram_done) begin
                if (!seen_low) begin
                    // Inputs after capture must be ignored.
                    sram_rw      = ~rw;
                    mem_bank_sel = ~bank;
                    pix_addr     = ~addr;
                    wr_data      = ~wd;
                end
                seen_low = 1'b1;
                t_low++;
                if (t_low >= hold) sram_trig = 1'b0;
            end else if (seen_low) begin
                break;
            end
        end
        chk("access_complete", {seen_low, sram_done}, 2'b11);
        sram_trig = 1'b0;
        $display("txn %s bank=%0d addr=%04h wdata=%02h rd_data=%02h done_low=%0d",
                 rw ? "rd" : "wr", bank, addr, wd, rd_data, t_low);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < (1 << SRAM_AW); i++) mem[i] = 16'h0000;
        for (int i = 0; i < (1 << 18); i++) ref_pix[i] = 8'h00;

        // Reset asserted between clock edges: outputs must go idle before any edge.
        #2 rst_in = 1'b0;
        #1;
        chk("rst_done", sram_done, 1'b1);
        chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 5'b11111);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_addr", sram_addr, 18'h0);
        chk("rst_dq", sram_dq, 16'h0000);
        #19 rst_in = 1'b1;

        // Write A5 to right bank pixel 5: high lane of word 0x08002.
        access(1'b0, 2'b01, 16'h0005, 8'hA5, 1);
        chk("wr_addr", t_addr, 18'h08002);
        chk("wr_ub_n", t_ub, 1'b0);
        chk("wr_lb_n", t_lb, 1'b1);
        chk("wr_we_cycles", t_we, 2);
        chk("wr_dq", t_dq, 16'hA5A5);
        chk("wr_done_low", t_low, 5);
        chk("wr_mem_word", mem[18'h08002], 16'hA500);

        // Read back against a known SRAM word.
        mem[18'h08002]   = 16'h5A3C;
        ref_pix[18'h10005] = 8'h5A;
        ref_pix[18'h10004] = 8'h3C;
        access(1'b1, 2'b01, 16'h0005, 8'h00, 1);
        chk("rd_hi_data", rd_data, 8'h5A);
        chk("rd_hi_ub_n", t_ub, 1'b0);
        chk("rd_hi_done_low", t_low, 5);
        chk("rd_hi_no_we", t_we, 0);
        access(1'b1, 2'b01, 16'h0004, 8'h00, 1);
        chk("rd_lo_data", rd_data, 8'h3C);
        chk("rd_lo_lanes", {t_ub, t_lb}, 2'b10);
        chk("rd_lo_addr", t_addr, 18'h08002);

        // Trig held for 20 cycles: one access, done released the edge after trig falls.
        access(1'b0, 2'b00, 16'h1234, 8'h66, 20);
        chk("held_done_low", t_low, 20);
        chk("held_ce_cycles", t_ce, WAIT + 2);
        chk("held_we_cycles", t_we, WAIT);

        // Reset pulse mid-cycle while idle clears rd_data immediately.
        @(posedge clk_in);
        #3 rst_in = 1'b0;
        #1;
        chk("rst2_rd_data", rd_data, 8'h00);
        chk("rst2_done", sram_done, 1'b1);
        #2 rst_in = 1'b1;

        // Reset during the write strobe of an access to bank 3, max address.
        @(posedge clk_in);
        #2;
        sram_rw = 1'b0; mem_bank_sel = 2'b11; pix_addr = 16'hFFFF; wr_data = 8'h77;
        sram_trig = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            if (!sram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        chk("midwr_we_seen", found, 1'b1);
        #1 rst_in = 1'b0;
        #1;
        chk("midwr_we_n", sram_we_n, 1'b1);
        chk("midwr_ce_n", sram_ce_n, 1'b1);
        chk("midwr_dq", sram_dq, 16'h0000);
        chk("midwr_done", sram_done, 1'b1);
        sram_trig = 1'b0;
        #1 rst_in = 1'b1;
        $display("txn wr bank=3 addr=ffff wdata=77 aborted by reset");

        access(1'b0, 2'b11, 16'hFFFF, 8'h81, 1);
        chk("max_addr", t_addr, 18'h1FFFF);
        chk("max_lanes", {t_ub, t_lb}, 2'b01);
        chk("max_done_low", t_low, 5);
        access(1'b1, 2'b11, 16'hFFFF, 8'h00, 1);
        chk("max_rd_data", rd_data, 8'h81);

        // Sweep of disparity bank: 256 writes then 256 reads.
        for (int i = 0; i < 256; i++)
            access(1'b0, 2'b10, 16'(i), 8'(i) ^ 8'hC3, 1);
        for (int i = 0; i < 256; i++) begin
            access(1'b1, 2'b10, 16'(i), 8'h00, 1);
            chk("sweep_rd", rd_data, 8'(i) ^ 8'hC3);
        end

        @(negedge clk_in);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
